// File: rtl/regfile32_scan.sv
// MIPS register file: 2^AW x DW, two combinational read ports, one write port,
// plus a sequential scan/dump port. Optional write-through reads: REGFILE_BYPASS_EN.
module regfile32_scan #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic [AW-1:0] wn,
  input  logic [DW-1:0] d,
  input  logic          we,
  input  logic          scan_start,
  output logic          scan_busy,
  output logic          scan_valid,
  output logic [AW-1:0] scan_idx,
  output logic [DW-1:0] scan_data,
  output logic          scan_done
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] wen;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;

  always_comb begin
    wen = '0;
    if (we && (wn != '0)) wen[wn] = 1'b1;
  end

  // Entry 0 is only ever touched by reset, so it stays zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wen[i]) regs_q[i] <= d;
      end
    end
  end

  always_comb begin
    qa = (rna == '0) ? '0 : regs_q[rna];
    qb = (rnb == '0) ? '0 : regs_q[rnb];
`ifdef REGFILE_BYPASS_EN
    if (we && (wn != '0) && (wn == rna)) qa = d;
    if (we && (wn != '0) && (wn == rnb)) qb = d;
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // The start request is registered only while idle, so requests made during a scan are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = (state_q == IDLE) && scan_start;
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        done_d  = 1'b0;
        valid_d = 1'b0;
        if (start_q) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        valid_d = 1'b1;
        idx_d   = cnt_q;
        data_d  = (cnt_q == '0) ? '0 : regs_q[cnt_q];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign scan_busy  = (state_q != IDLE);
  assign scan_valid = valid_q;
  assign scan_idx   = idx_q;
  assign scan_data  = data_q;
  assign scan_done  = done_q;

endmodule

// File: tb/tb_regfile32_scan.sv
// Self-checking bench for regfile32_scan: random read/write traffic against an
// array model, plus directed scan, scan-vs-write, start-while-busy and mid-scan reset.
module tb_regfile32_scan;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  rna, rnb, wn;
  logic [31:0] d, qa, qb;
  logic        we, scan_start;
  logic        scan_busy, scan_valid, scan_done;
  logic [4:0]  scan_idx;
  logic [31:0] scan_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_regs [32];
  logic [31:0] snap [32];

  regfile32_scan #(.DW(32), .AW(5)) dut (
    .clk(clk), .clrn(clrn),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .wn(wn), .d(d), .we(we),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_idx(scan_idx), .scan_data(scan_data), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] n);
    if (n == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && (wn != 5'd0) && (wn == n)) return d;
`endif
    return ref_regs[n];
  endfunction

  // One clock edge; the model commits the write that was presented before it.
  task automatic step();
    logic        w;
    logic [4:0]  n;
    logic [31:0] v;
    w = we; n = wn; v = d;
    @(posedge clk);
    #1;
    if (w && (n != 5'd0)) ref_regs[n] = v;
  endtask

  initial begin
    int cnt_v, cnt_d;
    bit found;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    clrn = 1'b0; we = 1'b0; wn = 5'd0; d = 32'h0;
    rna = 5'd5; rnb = 5'd31; scan_start = 1'b0;
    #12;
    chk("rst_qa", qa, 32'h0);
    chk("rst_qb", qb, 32'h0);
    chk("rst_valid", {31'h0, scan_valid}, 32'h0);
    chk("rst_busy", {31'h0, scan_busy}, 32'h0);
    chk("rst_done", {31'h0, scan_done}, 32'h0);
    chk("rst_idx", {27'h0, scan_idx}, 32'h0);
    chk("rst_data", scan_data, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // basic write/read and discarded write to register 0
    we = 1'b1; wn = 5'd8; d = 32'hDEADBEEF; rna = 5'd8;
    step();
    we = 1'b0; #1;
    chk("wr8_qa", qa, 32'hDEADBEEF);
    we = 1'b1; wn = 5'd0; d = 32'h12345678; rna = 5'd0; rnb = 5'd8;
    step();
    we = 1'b0; #1;
    chk("wr0_qa", qa, 32'h0);
    chk("wr0_qb_r8", qb, 32'hDEADBEEF);

    // read-during-write
    rna = 5'd9; we = 1'b1; wn = 5'd9; d = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre", qa, 32'hA5A5A5A5);
`else
    chk("byp_pre", qa, 32'h0);
`endif
    step();
    we = 1'b0; #1;
    chk("byp_post", qa, 32'hA5A5A5A5);

    // random traffic
    for (int it = 0; it < 300; it++) begin
      we  = ($urandom_range(0, 3) != 0);
      wn  = 5'($urandom_range(0, 31));
      d   = $urandom;
      rna = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      rnb = 5'($urandom_range(0, 31));
      #1;
      chk("rnd_qa", qa, model_read(rna));
      chk("rnd_qb", qb, model_read(rnb));
      step();
    end
    we = 1'b0;

    // full scan with known contents
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wn = 5'(i); d = i * 32'h0101;
      step();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) snap[i] = ref_regs[i];
    chk("snap_r0", snap[0], 32'h0);

    scan_start = 1'b1;
    step();                          // edge E samples start
    scan_start = 1'b0;
    chk("pre_valid", {31'h0, scan_valid}, 32'h0);
    step();                          // E+1
    chk("e1_busy", {31'h0, scan_busy}, 32'h1);
    chk("e1_valid", {31'h0, scan_valid}, 32'h0);
    for (int k = 0; k < 32; k++) begin
      if (k == 20) begin we = 1'b1; wn = 5'd20; d = 32'hFFFFFFFF; end
      if (k == 10) scan_start = 1'b1;
      step();                        // E+2+k
      we = 1'b0; scan_start = 1'b0;
      chk("scan_valid", {31'h0, scan_valid}, 32'h1);
      chk("scan_busy", {31'h0, scan_busy}, 32'h1);
      chk("scan_idx", {27'h0, scan_idx}, k);
      chk("scan_data", scan_data, snap[k]);
      chk("scan_done_lo", {31'h0, scan_done}, 32'h0);
    end
    step();                          // E+34
    chk("done_hi", {31'h0, scan_done}, 32'h1);
    chk("done_valid", {31'h0, scan_valid}, 32'h0);
    step();
    chk("done_lo", {31'h0, scan_done}, 32'h0);
    chk("idle_busy", {31'h0, scan_busy}, 32'h0);
    cnt_v = 0; cnt_d = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      cnt_v += scan_valid; cnt_d += scan_done;
    end
    chk("no_restart_valid", cnt_v, 0);
    chk("no_restart_done", cnt_d, 0);
    rna = 5'd20; #1;
    chk("r20_after", qa, 32'hFFFFFFFF);

    // reset in the middle of a scan
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      step();
      if (scan_valid && scan_idx == 5'd12) found = 1'b1;
    end
    chk("reach_idx12", {31'h0, found}, 32'h1);
    clrn = 1'b0; #1;
    chk("mrst_valid", {31'h0, scan_valid}, 32'h0);
    chk("mrst_busy", {31'h0, scan_busy}, 32'h0);
    chk("mrst_done", {31'h0, scan_done}, 32'h0);
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    rna = 5'd20; rnb = 5'd31; #1;
    chk("mrst_r20", qa, 32'h0);
    chk("mrst_r31", qb, 32'h0);
    @(negedge clk);
    clrn = 1'b1;
    cnt_d = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      cnt_d += scan_done;
    end
    chk("mrst_no_done", cnt_d, 0);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step();
    step();
    chk("restart_valid", {31'h0, scan_valid}, 32'h1);
    chk("restart_idx", {27'h0, scan_idx}, 32'h0);
    step();
    chk("restart_idx1", {27'h0, scan_idx}, 32'h1);
    chk("restart_data1", scan_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
